// File: rtl/pipe_stage_hs.sv
// Flushable valid/ready pipeline stage with a saturating stall counter.
// Define PIPE_SKID_EN for the two-entry skid variant with registered in_ready.
module pipe_stage_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_cnt
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
`ifdef PIPE_SKID_EN
  localparam logic [1:0] StFull  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [CNTW-1:0]  stall_q, stall_d;
  logic             in_fire, out_fire;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  assign in_ready = (state_q != StFull);
`else
  // Without a skid entry a held payload only makes room when it leaves this cycle.
  assign in_ready = (state_q == StEmpty) | out_ready;
`endif

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StOne;
          main_d  = in_data;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
`ifdef PIPE_SKID_EN
        end else if (in_fire) begin
          state_d = StFull;
          skid_d  = in_data;
`endif
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
`ifdef PIPE_SKID_EN
      StFull: begin
        if (out_fire) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
`endif
      default: state_d = StEmpty;
    endcase
    // Flush empties the stage but leaves the data registers untouched.
    if (flush) state_d = StEmpty;
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNTW{1'b1}})) stall_d = stall_q + CNTW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StEmpty;
      main_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      stall_q <= stall_d;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge CLK) begin
    if (!nRST) skid_q <= '0;
    else       skid_q <= skid_d;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_pipe_stage_hs;
  localparam int W = 16;
  localparam int C = 4;
`ifdef PIPE_SKID_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif
  localparam int SatMax = (1 << C) - 1;

  logic         CLK;
  logic         nRST;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   occupancy;
  logic [C-1:0] stall_cnt;

  pipe_stage_hs #(.WIDTH(W), .CNTW(C)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  logic [W-1:0] mq[$];
  int mstall = 0;
  bit known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Acceptance rule taken from the stage's capacity and the downstream ready.
  function automatic bit m_ready();
    if (Cap == 2) return mq.size() < 2;
    return (mq.size() == 0) || (out_ready == 1'b1);
  endfunction

  task automatic step();
    bit iv, rd, ord, fl, rs;
    logic [W-1:0] d;
    @(negedge CLK);
    if (known) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      chk("occupancy", {30'd0, occupancy}, mq.size());
      chk("stall_cnt", {28'd0, stall_cnt}, mstall);
      if (mq.size() > 0) chk("out_data", {16'd0, out_data}, {16'd0, mq[0]});
    end
    iv = in_valid; rd = m_ready(); ord = out_ready; fl = flush; rs = nRST; d = in_data;
    @(posedge CLK);
    if (!rs) begin
      mq.delete();
      mstall = 0;
      known = 1'b1;
    end else begin
      if (mq.size() > 0 && !ord && mstall < SatMax) mstall++;
      if (fl) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && ord) void'(mq.pop_front());
        if (iv && rd) mq.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    // Reset held two cycles with a live upstream payload.
    nRST = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b0; flush = 1'b0;
    step(); step();
    nRST = 1'b1; in_valid = 1'b0;
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Back-to-back streaming.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h000A; step();
    in_data = 16'h000B; step();
    in_valid = 1'b0;
    chk("bp_occ", {30'd0, occupancy}, Cap);
    chk("bp_data", {16'd0, out_data}, 32'h000A);
    step(); step();
    out_ready = 1'b1;
    step(); step(); step();

    // Flush while holding, with an incoming payload dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h000A; step();
    in_data = 16'h000B; step();
    in_data = 16'h000C; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step(); step();

    // Stall counter saturation.
    nRST = 1'b0; step(); nRST = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055; step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", {28'd0, stall_cnt}, SatMax);
    out_ready = 1'b1; step(); step();

    // Single held payload: ready follows downstream in the no-skid build.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011; step();
    in_data = 16'h0005; step();
    out_ready = 1'b1; step(); step();
    in_valid = 1'b0; step();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      nRST = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
